// File: rtl/transition_scan_control.sv
// transition_scan_control
// Control stage feeding the downstream transition counter. It latches a data
// word, issues the counter load instruction, then walks adjacent bit pairs
// LSB-first and emits a count instruction for every 0->1 step it finds.
// A one-cycle done pulse marks the cycle in which the counter value is final.
//
// Optional build macro: TRANSITION_SCAN_ABORT_EN
//   When defined, an extra 'abort' input lets the scan be dropped from LOAD
//   or SCAN without a done pulse. Reset still wins over abort.

module transition_scan_control #(
  parameter int WIDTH    = 8,
  parameter int CNT_BITS = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
`ifdef TRANSITION_SCAN_ABORT_EN
  input  logic                     abort,
`endif
  input  logic [WIDTH-1:0]         data_in,
  output logic [2:0]               instruction,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(WIDTH)-1:0] bit_index
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 2);

  localparam logic [2:0] INSTR_NOP   = 3'b000;
  localparam logic [2:0] INSTR_TRANS = 3'b001;
  localparam logic [2:0] INSTR_LOAD  = 3'b100;

  // The counter must be able to hold the worst-case number of transitions.
  if (WIDTH < 2) begin : g_badWidth
    $error("transition_scan_control: WIDTH must be at least 2");
  end
  if ((64'd1 << CNT_BITS) <= 64'(WIDTH - 1)) begin : g_badCntBits
    $error("transition_scan_control: CNT_BITS too narrow for WIDTH");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SCAN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [2:0]       r_instr;
  logic             r_busy;
  logic             r_done;
  logic [IDX_W-1:0] r_idx;

  logic             w_abort;
  logic             w_pairRise;

`ifdef TRANSITION_SCAN_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // The pair about to be emitted always sits in the two lowest shift bits.
  assign w_pairRise = (r_shift[1:0] == 2'b10);

  // Single FSM; every output is registered so it is decided one edge early.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_instr <= INSTR_NOP;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_instr <= INSTR_NOP;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_idx   <= '0;
          if (start) begin
            r_shift <= data_in;
            r_state <= S_LOAD;
            r_instr <= INSTR_LOAD;
            r_busy  <= 1'b1;
          end
        end
        S_LOAD: begin
          if (w_abort) begin
            r_state <= S_IDLE;
            r_instr <= INSTR_NOP;
            r_busy  <= 1'b0;
            r_idx   <= '0;
          end else begin
            r_state <= S_SCAN;
            r_instr <= w_pairRise ? INSTR_TRANS : INSTR_NOP;
            r_shift <= r_shift >> 1;
            r_idx   <= '0;
          end
        end
        S_SCAN: begin
          if (w_abort) begin
            r_state <= S_IDLE;
            r_instr <= INSTR_NOP;
            r_busy  <= 1'b0;
            r_idx   <= '0;
          end else if (r_idx == LAST_IDX) begin
            r_state <= S_DONE;
            r_instr <= INSTR_NOP;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_idx   <= '0;
          end else begin
            r_instr <= w_pairRise ? INSTR_TRANS : INSTR_NOP;
            r_shift <= r_shift >> 1;
            r_idx   <= r_idx + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_instr <= INSTR_NOP;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_idx   <= '0;
        end
        default: begin
          r_state <= S_IDLE;
          r_instr <= INSTR_NOP;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_idx   <= '0;
        end
      endcase
    end
  end

  assign instruction = r_instr;
  assign busy        = r_busy;
  assign done        = r_done;
  assign bit_index   = r_idx;

endmodule

// File: tb/tb_transition_scan_control.sv
// tb_transition_scan_control
// Scoreboard bench for transition_scan_control (WIDTH=8). Each accepted start
// pushes the full per-cycle output stream and the final transition count; a
// monitor pops and compares one entry per cycle and the count on every done.
// Abort scenarios are compiled in when TRANSITION_SCAN_ABORT_EN is defined.

module tb_transition_scan_control;

  localparam int WIDTH    = 8;
  localparam int CNT_BITS = 4;

  logic             clock;
  logic             reset;
  logic             start;
`ifdef TRANSITION_SCAN_ABORT_EN
  logic             abort;
`endif
  logic [WIDTH-1:0] data_in;
  logic [2:0]       instruction;
  logic             busy;
  logic             done;
  logic [2:0]       bit_index;

  int testsRun;
  int testsFailed;

  // Expected packed {instruction, busy, done, bit_index} per cycle.
  logic [7:0] expQ[$];
  int         resQ[$];
  int         benchCount;
  bit         monitorOn;

  transition_scan_control #(
    .WIDTH   (WIDTH),
    .CNT_BITS(CNT_BITS)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
`ifdef TRANSITION_SCAN_ABORT_EN
    .abort      (abort),
`endif
    .data_in    (data_in),
    .instruction(instruction),
    .busy       (busy),
    .done       (done),
    .bit_index  (bit_index)
  );

  // Free-running clock, period 10.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Build the expected output stream for one scan; cutAt > 0 truncates it at
  // the cycle where reset/abort hits, and then no result is expected.
  task automatic pushExpected(input logic [WIDTH-1:0] d, input int cutAt);
    int lastK;
    int rises;
    int i;
    logic rise;
    lastK = (cutAt > 0) ? cutAt : WIDTH + 1;
    rises = 0;
    for (int k = 1; k <= lastK; k++) begin
      if (k == 1) begin
        expQ.push_back({3'b100, 1'b1, 1'b0, 3'd0});
      end else if (k <= WIDTH) begin
        i = k - 2;
        rise = !d[i] && d[i+1];
        if (rise) rises++;
        expQ.push_back({rise ? 3'b001 : 3'b000, 1'b1, 1'b0, 3'(i)});
      end else begin
        expQ.push_back({3'b000, 1'b0, 1'b1, 3'd0});
      end
    end
    if (cutAt <= 0) resQ.push_back(rises);
  endtask

  // Drives one start. cutKind: 0 none, 1 reset, 2 abort, 3 abort+reset,
  // applied in the middle of cycle E+cutAt. holdNeg keeps start high that many
  // half-cycle points; data_in is scrambled right after capture.
  task automatic applyStimulus(input logic [WIDTH-1:0] d, input int cutAt,
                               input int cutKind, input int holdNeg);
    int lastK;
    @(negedge clock);
    start   = 1'b1;
    data_in = d;
    pushExpected(d, (cutKind != 0) ? cutAt : 0);
    lastK = (holdNeg > WIDTH + 1) ? holdNeg : WIDTH + 1;
    for (int k = 1; k <= lastK; k++) begin
      @(negedge clock);
      if (k >= holdNeg) start = 1'b0;
      data_in = ~d;
      if (cutKind != 0 && k == cutAt) begin
        if (cutKind == 1 || cutKind == 3) reset = 1'b1;
`ifdef TRANSITION_SCAN_ABORT_EN
        if (cutKind == 2 || cutKind == 3) abort = 1'b1;
`endif
        start = 1'b0;
        @(negedge clock);
        reset = 1'b0;
`ifdef TRANSITION_SCAN_ABORT_EN
        abort = 1'b0;
`endif
        break;
      end
    end
  endtask

  // Model of the downstream counter, fed from the DUT instruction stream.
  always @(posedge clock) begin
    if (reset) benchCount <= 0;
    else if (instruction == 3'b100) benchCount <= 0;
    else if (instruction == 3'b001) benchCount <= benchCount + 1;
  end

  // Per-cycle monitor sampling shortly after the edge; idle outputs are
  // expected whenever no scan entry is pending.
  always @(posedge clock) begin
    logic [7:0] obs;
    logic [7:0] exp;
    int pend;
    #2;
    if (monitorOn) begin
      obs = {instruction, busy, done, bit_index};
      exp = (expQ.size() > 0) ? expQ.pop_front() : 8'h00;
      checkOutput("cycle", {24'd0, obs}, {24'd0, exp});
      if (done) begin
        pend = resQ.size();
        checkOutput("resultPending", (pend != 0) ? 32'd1 : 32'd0, 32'd1);
        if (pend != 0) checkOutput("result", benchCount, resQ.pop_front());
      end
    end
  end

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    monitorOn   = 1'b0;
    reset       = 1'b1;
    start       = 1'b0;
    data_in     = '0;
`ifdef TRANSITION_SCAN_ABORT_EN
    abort       = 1'b0;
`endif
    repeat (3) @(negedge clock);
    reset     = 1'b0;
    monitorOn = 1'b1;
    repeat (2) @(negedge clock);

    // Alternating patterns.
    applyStimulus(8'b10101010, 0, 0, 1);
    repeat (2) @(negedge clock);
    applyStimulus(8'b01010101, 0, 0, 1);
    repeat (2) @(negedge clock);

    // Back-to-back: second start lands in the IDLE cycle right after done.
    applyStimulus(8'h00, 0, 0, 1);
    applyStimulus(8'hFF, 0, 0, 1);
    repeat (2) @(negedge clock);

    // start held through the whole scan and DONE: only one scan.
    applyStimulus(8'hF0, 0, 0, 10);
    repeat (2) @(negedge clock);

    // Reset while bit_index=3, then a clean rerun.
    applyStimulus(8'b10101010, 5, 1, 1);
    repeat (2) @(negedge clock);
    applyStimulus(8'b10101010, 0, 0, 1);
    repeat (2) @(negedge clock);

    // Reset right in LOAD.
    applyStimulus(8'h5A, 1, 1, 1);
    repeat (2) @(negedge clock);

`ifdef TRANSITION_SCAN_ABORT_EN
    // Abort at bit_index=2.
    applyStimulus(8'b10101010, 4, 2, 1);
    repeat (2) @(negedge clock);
    // Abort in IDLE does nothing.
    abort = 1'b1;
    repeat (3) @(negedge clock);
    abort = 1'b0;
    // Abort together with reset behaves like reset.
    applyStimulus(8'h3C, 3, 3, 1);
    repeat (2) @(negedge clock);
    applyStimulus(8'h96, 0, 0, 1);
    repeat (2) @(negedge clock);
`endif

    repeat (3) @(negedge clock);
    checkOutput("expDrain", expQ.size(), 32'd0);
    checkOutput("resDrain", resQ.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
